// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//   Shares one DW-bit equality comparator between NREQ requesters. A
//   round-robin arbiter grants one request at a time. The granted operands
//   are latched, compared one cycle later, and the registered result is
//   returned to the owner over a valid/ready response channel.
//
//   Optional feature: define CMP_ARB_PERF_EN to add the grant_cnt and
//   wait_cnt performance counters.
//
// Handshakes:
//   Request: a transfer happens on a rising edge where req_valid[i] and
//   req_ready[i] are both high. A requester keeps req_valid and its operands
//   stable until that edge. It may drop req_valid before being granted.
//   Response: a transfer happens on a rising edge where resp_valid and
//   resp_ready are both high. resp_valid, resp_eq and resp_id stay stable
//   until then.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   req_valid       per-requester request valid            [NREQ]
//   req_ready       per-requester accept, one-hot or zero   [NREQ]
//   req_a, req_b    flattened operands, slice i = [i*DW +: DW]
//   resp_valid      result valid
//   resp_ready      result consumed
//   resp_eq         1 = operands equal
//   resp_id         index of the requester that owns the result [IDW]
//   busy            FSM not in IDLE
//   grant_cnt       (CMP_ARB_PERF_EN) accepted requests, saturating
//   wait_cnt        (CMP_ARB_PERF_EN) stalled request cycles, saturating

`ifndef DATASIZE
`define DATASIZE 32
`endif

module cmp_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int DW   = `DATASIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_eq,
  output logic [IDW-1:0]     resp_id,
  output logic               busy
`ifdef CMP_ARB_PERF_EN
  ,
  output logic [15:0]        grant_cnt,
  output logic [15:0]        wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;

  logic [IDW-1:0] winner;
  logic           found;
  logic           grant_en;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic           eq;

  // Round-robin pick. The first pass looks at indices at or above rr_ptr.
  // The second pass wraps around to the low indices. This avoids a modulo
  // and works for any NREQ, including non-powers of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  // Grants are only issued from IDLE. They are also held off while reset is
  // asserted, so req_ready reads zero during reset.
  assign grant_en = !rst && (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        req_ready[i] = grant_en;
        sel_a        = req_a[i*DW +: DW];
        sel_b        = req_b[i*DW +: DW];
      end
    end
  end

  // The shared comparator only ever sees the latched operands, so requesters
  // are free to change their buses once they have been granted.
  assign eq = (op_a == op_b);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_eq    <= 1'b0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= winner;
            state  <= CMP;
          end
        end
        CMP: begin
          resp_eq    <= eq;
          resp_valid <= 1'b1;
          resp_id    <= cur_id;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            // The pointer moves past the requester just served. It wraps
            // explicitly so it never reaches NREQ.
            rr_ptr     <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if ((|req_ready) && (grant_cnt != 16'hFFFF)) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
      if ((|req_valid) && (req_ready == '0) && (wait_cnt != 16'hFFFF)) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed testbench for cmp_arbiter (NREQ=4, IDW=3, DW=32).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 2 time units after the rising edge.

module tb_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int DW   = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_eq;
  logic [IDW-1:0]     resp_id;
  logic               busy;
`ifdef CMP_ARB_PERF_EN
  logic [15:0]        grant_cnt;
  logic [15:0]        wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW),
    .DW  (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_eq   (resp_eq),
    .resp_id   (resp_id),
    .busy      (busy)
`ifdef CMP_ARB_PERF_EN
    ,
    .grant_cnt (grant_cnt),
    .wait_cnt  (wait_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b expected 0", resp_valid); end
    checks++; if (resp_eq !== 1'b0) begin errors++; $display("FAIL reset_resp_eq: got %0b expected 0", resp_eq); end
    checks++; if (resp_id !== 3'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
`ifdef CMP_ARB_PERF_EN
    checks++; if (grant_cnt !== 16'd0 || wait_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", grant_cnt, wait_cnt); end
`endif
    req_valid = '0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_single();
    tick();
    req_a[0*DW +: DW] = 32'hDEADBEEF;
    req_b[0*DW +: DW] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0000 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_cmp_state: got busy=%0b ready=%b rv=%0b expected 1/0000/0", busy, req_ready, resp_valid); end
    tick();
    #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %0b expected 1", resp_valid); end
    checks++; if (resp_eq !== 1'b1) begin errors++; $display("FAIL single_resp_eq: got %0b expected 1", resp_eq); end
    checks++; if (resp_id !== 3'd0) begin errors++; $display("FAIL single_resp_id: got %0d expected 0", resp_id); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got rv=%0b busy=%0b expected 0/0", resp_valid, busy); end
  endtask

  task automatic test_mismatch();
    tick();
    req_a[2*DW +: DW] = 32'd5;
    req_b[2*DW +: DW] = 32'd6;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mismatch_grant: got %b expected 0100", req_ready); end
    tick();
    // The live bus now matches. The latched operands still differ.
    req_valid = 4'b0000;
    req_b[2*DW +: DW] = 32'd5;
    tick();
    #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL mismatch_resp_valid: got %0b expected 1", resp_valid); end
    checks++; if (resp_eq !== 1'b0) begin errors++; $display("FAIL mismatch_resp_eq: got %0b expected 0", resp_eq); end
    checks++; if (resp_id !== 3'd2) begin errors++; $display("FAIL mismatch_resp_id: got %0d expected 2", resp_id); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mismatch_release: got %0b expected 0", resp_valid); end
  endtask

  // All four requesters stay valid and resp_ready is held high. The expected
  // grant order is 0,1,2,3,0 with one grant every 3 cycles. Even requesters
  // present equal operands and odd requesters present unequal ones.
  task automatic test_round_robin();
    int grants;
    int last_k;
    int exp_id;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = 32'h100 + i;
      req_b[i*DW +: DW] = (i % 2 == 1) ? (32'h100 + i) ^ 32'h1 : 32'h100 + i;
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    grants     = 0;
    last_k     = -1;
    for (int k = 0; k <= 12; k++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        exp_id = grants % NREQ;
        checks++; if (req_ready !== (NREQ'(1) << exp_id)) begin errors++; $display("FAIL rr_order: grant %0d got %b expected id %0d", grants, req_ready, exp_id); end
        if (grants > 0) begin
          checks++; if (k - last_k != 3) begin errors++; $display("FAIL rr_interval: got %0d cycles expected 3", k - last_k); end
        end
        last_k = k;
        grants++;
      end
      if (resp_valid === 1'b1) begin
        exp_id = (grants - 1) % NREQ;
        checks++; if (resp_id !== IDW'(exp_id)) begin errors++; $display("FAIL rr_resp_id: got %0d expected %0d", resp_id, exp_id); end
        checks++; if (resp_eq !== (exp_id % 2 == 0)) begin errors++; $display("FAIL rr_resp_eq: id %0d got %0b expected %0b", exp_id, resp_eq, (exp_id % 2 == 0)); end
      end
`ifdef CMP_ARB_PERF_EN
      if (k == 10) begin
        checks++; if (grant_cnt !== 16'd4) begin errors++; $display("FAIL perf_grant_cnt_4: got %0d expected 4", grant_cnt); end
        checks++; if (wait_cnt !== 16'd6) begin errors++; $display("FAIL perf_wait_cnt_4: got %0d expected 6", wait_cnt); end
      end
`endif
      tick();
    end
    req_valid = 4'b0000;
    checks++; if (grants != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", grants); end
    #1;
`ifdef CMP_ARB_PERF_EN
    checks++; if (grant_cnt !== 16'd5 || wait_cnt !== 16'd8) begin errors++; $display("FAIL perf_final: got %0d/%0d expected 5/8", grant_cnt, wait_cnt); end
`endif
    for (int n = 0; n < 10 && busy === 1'b1; n++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain: busy got %0b expected 0 within 10 cycles", busy); end
    resp_ready = 1'b0;
  endtask

  // rr_ptr is 1 here, so a lone request from requester 3 wins. The response
  // is then held for 5 cycles while the other requesters wait.
  task automatic test_backpressure();
    tick();
    req_a[3*DW +: DW] = 32'hCAFE0003;
    req_b[3*DW +: DW] = 32'hCAFE0003;
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0111;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd3 || resp_eq !== 1'b1) begin errors++; $display("FAIL bp_hold: cycle %0d got rv=%0b id=%0d eq=%0b expected 1/3/1", c, resp_valid, resp_id, resp_eq); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant: cycle %0d got %b expected 0000", c, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b expected 0", resp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    // Dropping the request before the edge withdraws it cleanly.
    req_valid = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_drop: got %b expected 0000", req_ready); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy got %0b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    tick();
    req_a[2*DW +: DW] = 32'd7;
    req_b[2*DW +: DW] = 32'd7;
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    // rr_ptr is now 3. A lone request from 1 wraps around to be granted.
    req_a[1*DW +: DW] = 32'd9;
    req_b[1*DW +: DW] = 32'd9;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_wrap_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rm_async: got rv=%0b busy=%0b ready=%b expected 0/0/0000", resp_valid, busy, req_ready); end
    tick();
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_discard: got %0b expected 0", resp_valid); end
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_restart: got %b expected 0001", req_ready); end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_mismatch();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
